commit_ctrl: RTL and testbench

//  In-order commit sequencer for the order_queue (32-entry Rd-tag FIFO). Gates dispatch

---
 rtl/oq_pkg.sv | 29 ++
 rtl/tag_scoreboard.sv | 44 ++++
 rtl/commit_ctrl.sv | 129 ++++++++++++
 tb/tb_commit_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oq_pkg.sv
// Shared constants and commit-state type for the order_queue commit path.
// Build option: COMMIT_STATS_EN (see commit_ctrl).
package oq_pkg;

   localparam int TAG_W = 5;
   localparam int NTAGS = 1 << TAG_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      STALL  = 2'd2,
      RETIRE = 2'd3
   } commit_state_e;

   // Priority IDLE > WAIT > STALL > RETIRE; RETIRE is exactly the pop condition.
   function automatic commit_state_e next_state(input logic empty,
                                                input logic head_done,
                                                input logic stall);
      if (empty)
         return IDLE;
      else if (!head_done)
         return WAIT;
      else if (stall)
         return STALL;
      else
         return RETIRE;
   endfunction

endpackage

// File: rtl/tag_scoreboard.sv
// Per-tag completion flags: set by CDB, cleared by dispatch or commit, async read.
// A clear always beats a set on the same tag in the same cycle.
module tag_scoreboard
   import oq_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             set_en,
   input  logic [TAG_W-1:0] set_tag,
   input  logic             disp_clr_en,
   input  logic [TAG_W-1:0] disp_clr_tag,
   input  logic             pop_clr_en,
   input  logic [TAG_W-1:0] pop_clr_tag,
   input  logic [TAG_W-1:0] rd_tag,
   output logic             rd_done
);

   logic [NTAGS-1:0] done_q;
   logic [NTAGS-1:0] done_d;

   generate
      for (genvar gi = 0; gi < NTAGS; gi++) begin : g_entry
         logic set_hit;
         logic clr_hit;

         assign set_hit = set_en && (set_tag == TAG_W'(gi));
         assign clr_hit = (disp_clr_en && (disp_clr_tag == TAG_W'(gi))) ||
                          (pop_clr_en  && (pop_clr_tag  == TAG_W'(gi)));

         assign done_d[gi] = clr_hit ? 1'b0 : (set_hit ? 1'b1 : done_q[gi]);
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         done_q <= '0;
      else
         done_q <= done_d;
   end

   // No bypass: a completion written this edge is visible only next cycle.
   assign rd_done = done_q[rd_tag];

endmodule

// File: rtl/commit_ctrl.sv
// In-order commit sequencer for the order_queue: gates dispatch pushes, tracks
// completions and pops the head tag once done. Optional counters: COMMIT_STATS_EN.
module commit_ctrl
   import oq_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             disp_valid,
   input  logic [TAG_W-1:0] disp_tag,
   output logic             disp_ready,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic             commit_stall,
   output logic [TAG_W-1:0] oq_in_data,
   output logic             oq_new_data,
   output logic             oq_out_data,
   input  logic [TAG_W-1:0] oq_data,
   input  logic             oq_full,
   input  logic             oq_empty,
   output logic             commit_valid,
   output logic [TAG_W-1:0] commit_tag,
   output logic [TAG_W:0]   pending_cnt
`ifdef COMMIT_STATS_EN
   ,
   output logic [31:0]      stat_commits,
   output logic [31:0]      stat_stalls
`endif
);

   logic             push;
   logic             pop;
   logic             head_done;

   commit_state_e    state_q;
   commit_state_e    state_d;
   logic             commit_valid_q;
   logic             commit_valid_d;
   logic [TAG_W-1:0] commit_tag_q;
   logic [TAG_W-1:0] commit_tag_d;
   logic [TAG_W:0]   pending_cnt_q;
   logic [TAG_W:0]   pending_cnt_d;
   logic             state_unused;

`ifdef COMMIT_STATS_EN
   logic [31:0]      stat_commits_q;
   logic [31:0]      stat_commits_d;
   logic [31:0]      stat_stalls_q;
   logic [31:0]      stat_stalls_d;
`endif

   tag_scoreboard u_sb (
      .clock        (clock),
      .reset        (reset),
      .set_en       (cdb_valid),
      .set_tag      (cdb_tag),
      .disp_clr_en  (push),
      .disp_clr_tag (disp_tag),
      .pop_clr_en   (pop),
      .pop_clr_tag  (oq_data),
      .rd_tag       (oq_data),
      .rd_done      (head_done)
   );

   // The full flag alone gates dispatch; a same-cycle pop never admits a push.
   always_comb begin
      disp_ready  = !oq_full;
      push        = disp_valid && !oq_full;
      pop         = !oq_empty && head_done && !commit_stall;
      oq_in_data  = disp_tag;
      oq_new_data = push;
      oq_out_data = pop;
   end

   always_comb begin
      state_d        = next_state(oq_empty, head_done, commit_stall);
      commit_valid_d = pop;
      commit_tag_d   = pop ? oq_data : commit_tag_q;
      pending_cnt_d  = pending_cnt_q;
      case ({push, pop})
         2'b10:   pending_cnt_d = pending_cnt_q + (TAG_W+1)'(1);
         2'b01:   pending_cnt_d = pending_cnt_q - (TAG_W+1)'(1);
         default: pending_cnt_d = pending_cnt_q;
      endcase
   end

`ifdef COMMIT_STATS_EN
   always_comb begin
      stat_commits_d = stat_commits_q + {31'd0, pop};
      stat_stalls_d  = stat_stalls_q;
      if ((state_d == WAIT) || (state_d == STALL))
         stat_stalls_d = stat_stalls_q + 32'd1;
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         commit_valid_q <= 1'b0;
         commit_tag_q   <= '0;
         pending_cnt_q  <= '0;
`ifdef COMMIT_STATS_EN
         stat_commits_q <= '0;
         stat_stalls_q  <= '0;
`endif
      end else begin
         state_q        <= state_d;
         commit_valid_q <= commit_valid_d;
         commit_tag_q   <= commit_tag_d;
         pending_cnt_q  <= pending_cnt_d;
`ifdef COMMIT_STATS_EN
         stat_commits_q <= stat_commits_d;
         stat_stalls_q  <= stat_stalls_d;
`endif
      end
   end

   // The state register is for observation only and steers no output.
   assign state_unused = ^state_q;

   assign commit_valid = commit_valid_q;
   assign commit_tag   = commit_tag_q;
   assign pending_cnt  = pending_cnt_q;

`ifdef COMMIT_STATS_EN
   assign stat_commits = stat_commits_q;
   assign stat_stalls  = stat_stalls_q;
`endif

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed bench for commit_ctrl with a behavioural order_queue and a commit scoreboard.
// Stats checks are compiled in when COMMIT_STATS_EN is defined.
module tb_commit_ctrl;
   import oq_pkg::*;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             disp_valid;
   logic [TAG_W-1:0] disp_tag;
   logic             disp_ready;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic             commit_stall;
   logic [TAG_W-1:0] oq_in_data;
   logic             oq_new_data;
   logic             oq_out_data;
   logic [TAG_W-1:0] oq_data;
   logic             oq_full;
   logic             oq_empty;
   logic             commit_valid;
   logic [TAG_W-1:0] commit_tag;
   logic [TAG_W:0]   pending_cnt;
`ifdef COMMIT_STATS_EN
   logic [31:0]      stat_commits;
   logic [31:0]      stat_stalls;
`endif

   int checks = 0;
   int errors = 0;
   logic [TAG_W-1:0] exp_q[$];

   // order_queue model; outputs can be overridden to probe the head read port
   logic [TAG_W-1:0] m_mem [NTAGS];
   logic [TAG_W-1:0] m_wr, m_rd;
   logic [TAG_W:0]   m_cnt;
   logic             m_full;
   logic             s_push = 1'b0;
   logic             s_pop = 1'b0;
   logic [TAG_W-1:0] s_tag = '0;
   logic             ovr;
   logic [TAG_W-1:0] ovr_data;

   always #50 clock = ~clock;

   commit_ctrl u_dut (
      .clock        (clock),
      .reset        (reset),
      .disp_valid   (disp_valid),
      .disp_tag     (disp_tag),
      .disp_ready   (disp_ready),
      .cdb_valid    (cdb_valid),
      .cdb_tag      (cdb_tag),
      .commit_stall (commit_stall),
      .oq_in_data   (oq_in_data),
      .oq_new_data  (oq_new_data),
      .oq_out_data  (oq_out_data),
      .oq_data      (oq_data),
      .oq_full      (oq_full),
      .oq_empty     (oq_empty),
      .commit_valid (commit_valid),
      .commit_tag   (commit_tag),
      .pending_cnt  (pending_cnt)
`ifdef COMMIT_STATS_EN
      ,
      .stat_commits (stat_commits),
      .stat_stalls  (stat_stalls)
`endif
   );

   always @(negedge clock) begin
      s_push <= oq_new_data;
      s_pop  <= oq_out_data;
      s_tag  <= oq_in_data;
   end

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_wr  <= '0;
         m_rd  <= '0;
         m_cnt <= '0;
      end else begin
         if (s_push) begin
            m_mem[m_wr] <= s_tag;
            m_wr        <= m_wr + 1'b1;
         end
         if (s_pop && m_cnt != 0)
            m_rd <= m_rd + 1'b1;
         m_cnt <= m_cnt + {{TAG_W{1'b0}}, s_push} - {{TAG_W{1'b0}}, (s_pop && m_cnt != 0)};
      end
   end

   always_comb begin
      m_full   = (m_cnt == (TAG_W+1)'(NTAGS));
      oq_data  = ovr ? ovr_data : m_mem[m_rd];
      oq_empty = ovr ? 1'b0 : (m_cnt == 0);
      oq_full  = ovr ? 1'b0 : m_full;
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      if (commit_valid === 1'b1) begin
         $display("commit tag=%0d pending=%0d", commit_tag, pending_cnt);
         if (exp_q.size() == 0)
            chk("commit_unexpected", 32'(commit_valid), 32'd0);
         else
            chk("commit_tag", 32'(commit_tag), 32'(exp_q.pop_front()));
      end
   endtask

   task automatic drive(input logic dv, input logic [TAG_W-1:0] dt,
                        input logic cv, input logic [TAG_W-1:0] ct, input logic st);
      disp_valid   = dv;
      disp_tag     = dt;
      cdb_valid    = cv;
      cdb_tag      = ct;
      commit_stall = st;
      #1;
      if (dv && !m_full) begin
         exp_q.push_back(dt);
         $display("dispatch tag=%0d", dt);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      disp_valid = 0; disp_tag = '0; cdb_valid = 0; cdb_tag = '0; commit_stall = 0;
      ovr = 0; ovr_data = '0;
      reset = 1;
      tick();
      tick();
      reset = 0;
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      chk("rst_commit_valid", 32'(commit_valid), 32'd0);
      chk("rst_commit_tag", 32'(commit_tag), 32'd0);
      chk("rst_pending", 32'(pending_cnt), 32'd0);
      chk("rst_disp_ready", 32'(disp_ready), 32'd1);
      chk("rst_pop", 32'(oq_out_data), 32'd0);

      // Reset mid-stream
      drive(1'b1, 5'd10, 1'b0, '0, 1'b0); tick();
      drive(1'b1, 5'd11, 1'b0, '0, 1'b0); tick();
      drive(1'b1, 5'd12, 1'b0, '0, 1'b0); tick();
      drive(1'b0, '0, 1'b1, 5'd10, 1'b0);
      chk("t1_no_bypass", 32'(oq_out_data), 32'd0);
      tick();
      drive(1'b0, '0, 1'b1, 5'd12, 1'b0);
      chk("t1_pop10", 32'(oq_out_data), 32'd1);
      tick();
      chk("t1_cv_before_rst", 32'(commit_valid), 32'd1);
      chk("t1_pend_before_rst", 32'(pending_cnt), 32'd2);
      disp_valid = 0; cdb_valid = 0;
      reset = 1;
      #1;
      chk("t1_rst_commit_valid", 32'(commit_valid), 32'd0);
      chk("t1_rst_pending", 32'(pending_cnt), 32'd0);
      ovr = 1;
      for (int t = 0; t < NTAGS; t++) begin
         ovr_data = TAG_W'(t);
         #1;
         chk($sformatf("t1_done_clear_%0d", t), 32'(oq_out_data), 32'd0);
      end
      ovr = 0;
      exp_q.delete();
      tick();
      reset = 0;
      tick();

      // In-order commit: 3,7,1
      drive(1'b1, 5'd3, 1'b0, '0, 1'b0); tick();
      drive(1'b1, 5'd7, 1'b0, '0, 1'b0); tick();
      drive(1'b1, 5'd1, 1'b0, '0, 1'b0); tick();
      chk("t2_pending3", 32'(pending_cnt), 32'd3);
      drive(1'b0, '0, 1'b1, 5'd7, 1'b0);
      chk("t2_wait_a", 32'(oq_out_data), 32'd0);
      tick();
      drive(1'b0, '0, 1'b1, 5'd1, 1'b0);
      chk("t2_wait_b", 32'(oq_out_data), 32'd0);
      tick();
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      chk("t2_wait_c", 32'(oq_out_data), 32'd0);
      tick();
      chk("t2_no_commit", 32'(commit_valid), 32'd0);
      drive(1'b0, '0, 1'b1, 5'd3, 1'b0);
      chk("t2_no_bypass", 32'(oq_out_data), 32'd0);
      tick();
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      chk("t2_pop3", 32'(oq_out_data), 32'd1);
      tick();
      chk("t2_cv3", 32'(commit_valid), 32'd1);
      chk("t2_pend2", 32'(pending_cnt), 32'd2);
      chk("t2_pop7", 32'(oq_out_data), 32'd1);
      tick();
      chk("t2_cv7", 32'(commit_valid), 32'd1);
      chk("t2_pend1", 32'(pending_cnt), 32'd1);
      tick();
      chk("t2_cv1", 32'(commit_valid), 32'd1);
      chk("t2_pend0", 32'(pending_cnt), 32'd0);
`ifdef COMMIT_STATS_EN
      chk("t6_stat_commits", stat_commits, 32'd3);
      chk("t6_stat_stalls", stat_stalls, 32'd6);
`endif
      tick();
      chk("t2_cv_idle", 32'(commit_valid), 32'd0);

      // Full boundary
      for (int t = 0; t < NTAGS; t++) begin
         drive(1'b1, TAG_W'(t), 1'b0, '0, 1'b0);
         tick();
      end
      chk("t3_pend_full", 32'(pending_cnt), 32'd32);
      drive(1'b1, 5'd0, 1'b0, '0, 1'b0);
      chk("t3_ready_full", 32'(disp_ready), 32'd0);
      chk("t3_push_full", 32'(oq_new_data), 32'd0);
      tick();
      chk("t3_pend_hold", 32'(pending_cnt), 32'd32);
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
      tick();
      drive(1'b1, 5'd0, 1'b0, '0, 1'b0);
      chk("t3_pop_at_full", 32'(oq_out_data), 32'd1);
      chk("t3_ready_pop", 32'(disp_ready), 32'd0);
      chk("t3_push_pop", 32'(oq_new_data), 32'd0);
      tick();
      chk("t3_pend31", 32'(pending_cnt), 32'd31);
      drive(1'b1, 5'd0, 1'b0, '0, 1'b0);
      chk("t3_ready_after", 32'(disp_ready), 32'd1);
      chk("t3_push_after", 32'(oq_new_data), 32'd1);
      tick();
      chk("t3_pend_refill", 32'(pending_cnt), 32'd32);
      for (int t = 1; t < NTAGS; t++) begin
         drive(1'b0, '0, 1'b1, TAG_W'(t), 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b1, 5'd0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 8 && pending_cnt != 0; i++)
         tick();
      chk("t3_drained", 32'(pending_cnt), 32'd0);
      tick();

      // Stall on a done head
      drive(1'b1, 5'd5, 1'b0, '0, 1'b1); tick();
      drive(1'b0, '0, 1'b1, 5'd5, 1'b1); tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, '0, 1'b0, '0, 1'b1);
         chk("t4_no_pop", 32'(oq_out_data), 32'd0);
         tick();
         chk("t4_state", 32'(u_dut.state_q), 32'(STALL));
         chk("t4_no_commit", 32'(commit_valid), 32'd0);
      end
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      chk("t4_release_pop", 32'(oq_out_data), 32'd1);
      tick();
      chk("t4_cv", 32'(commit_valid), 32'd1);
      chk("t4_tag", 32'(commit_tag), 32'd5);
      tick();
      chk("t4_pend0", 32'(pending_cnt), 32'd0);

      // Dispatch/completion collision on tag 9
      drive(1'b1, 5'd9, 1'b1, 5'd9, 1'b0); tick();
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      chk("t5_collide_a", 32'(oq_out_data), 32'd0);
      tick();
      chk("t5_collide_b", 32'(oq_out_data), 32'd0);
      drive(1'b0, '0, 1'b1, 5'd9, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      chk("t5_pop9", 32'(oq_out_data), 32'd1);
      tick();
      chk("t5_cv", 32'(commit_valid), 32'd1);
      chk("t5_tag", 32'(commit_tag), 32'd9);
      tick();

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
